t05_bit_stream_arbiter: RTL and testbench

Shares the single compressed-output path between the two bit-serial producers of the compression pipeline: the header synthesizer and the codeword emitter. Grants one producer at a time for a complete segment, packs accepted bits MSB-first into memory words, writes full words to SRAM through a request/acknowledge handshake, and zero-pads and writes the final partial word on flush.

---
 rtl/t05_bit_stream_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_t05_bit_stream_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t05_bit_stream_arbiter.sv
// t05_bit_stream_arbiter: shares one packed-word SRAM write path between
// the header synthesizer and codeword emitter bit-serial producers.
module t05_bit_stream_arbiter #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hdr_req,
    input  logic              hdr_bit,
    input  logic              hdr_valid,
    input  logic              hdr_last,
    input  logic              cmp_req,
    input  logic              cmp_bit,
    input  logic              cmp_valid,
    input  logic              cmp_last,
    output logic              hdr_gnt,
    output logic              cmp_gnt,
    output logic              ready,
    input  logic              flush,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [23:0]       bit_count
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_CMP   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_hdr;
    logic [WORD_W-1:0] r_pack;
    logic [CNT_W-1:0]  r_pack_cnt;
    logic [WORD_W-1:0] r_pend;
    logic              r_pend_full;
    logic [ADDR_W-1:0] r_addr;
    logic [23:0]       r_bit_cnt;
    logic              r_err;
    logic              r_flush_pend;

    logic              w_ready;
    logic              w_acc_hdr;
    logic              w_acc_cmp;
    logic              w_acc;
    logic              w_bit;
    logic [CNT_W-1:0]  w_bit_idx;
    logic              w_word_done;
    logic [WORD_W-1:0] w_full_word;
    logic              w_pad_move;
    logic              w_ack;
    logic              w_flush_done;
    logic              w_flush_req;
    logic              w_start;
    logic              w_err_evt;

    assign w_ready      = !(r_pend_full && (r_pack_cnt == LAST_IDX));
    assign w_acc_hdr    = (r_state == S_HDR) && hdr_valid && w_ready;
    assign w_acc_cmp    = (r_state == S_CMP) && cmp_valid && w_ready;
    assign w_acc        = w_acc_hdr || w_acc_cmp;
    assign w_bit        = w_acc_hdr ? hdr_bit : cmp_bit;
    assign w_bit_idx    = LAST_IDX - r_pack_cnt;
    assign w_word_done  = w_acc && (r_pack_cnt == LAST_IDX);
    // The final bit always lands in bit 0, so OR it into the packed bits.
    assign w_full_word  = r_pack | WORD_W'(w_bit);
    assign w_pad_move   = (r_state == S_FLUSH) && (r_pack_cnt != '0)
                          && !r_pend_full;
    assign w_ack        = r_pend_full && mem_ack;
    assign w_flush_done = (r_state == S_FLUSH) && (r_pack_cnt == '0)
                          && !r_pend_full;
    assign w_flush_req  = flush || r_flush_pend;
    assign w_start      = start && (r_state == S_IDLE);
    assign w_err_evt    = (hdr_valid && ((r_state != S_HDR) || !w_ready))
                       || (cmp_valid && ((r_state != S_CMP) || !w_ready))
                       || (hdr_last && (r_state != S_HDR))
                       || (cmp_last && (r_state != S_CMP));

    // State register and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last_hdr <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_HDR)
                r_last_hdr <= 1'b1;
            else if (r_state == S_IDLE && w_next == S_CMP)
                r_last_hdr <= 1'b0;
        end
    end

    // Next-state: flush outranks requests, ties go to the producer not last served.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_flush_req)
                    w_next = S_FLUSH;
                else if (hdr_req && cmp_req)
                    w_next = r_last_hdr ? S_CMP : S_HDR;
                else if (hdr_req)
                    w_next = S_HDR;
                else if (cmp_req)
                    w_next = S_CMP;
            end
            S_HDR:   if (hdr_last) w_next = S_IDLE;
            S_CMP:   if (cmp_last) w_next = S_IDLE;
            S_FLUSH: if (w_flush_done) w_next = S_IDLE;
        endcase
    end

    // Decoded FSM outputs.
    always_comb begin
        hdr_gnt = (r_state == S_HDR);
        cmp_gnt = (r_state == S_CMP);
        done    = w_flush_done;
        busy    = (r_state != S_IDLE) || r_pend_full;
    end

    // Bit packer, MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack     <= '0;
            r_pack_cnt <= '0;
        end else if (w_word_done || w_pad_move) begin
            r_pack     <= '0;
            r_pack_cnt <= '0;
        end else if (w_acc) begin
            r_pack[w_bit_idx] <= w_bit;
            r_pack_cnt        <= r_pack_cnt + 1'b1;
        end
    end

    // Pending word register; a new word overrides a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else if (w_word_done) begin
            r_pend      <= w_full_word;
            r_pend_full <= 1'b1;
        end else if (w_pad_move) begin
            r_pend      <= r_pack;
            r_pend_full <= 1'b1;
        end else if (w_ack) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end
    end

    // Write address, bit counter, sticky error and flush latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_bit_cnt    <= '0;
            r_err        <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_start)
                r_addr <= base_addr;
            else if (w_ack)
                r_addr <= r_addr + 1'b1;
            if (w_start)
                r_bit_cnt <= '0;
            else if (w_acc)
                r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_start)
                r_err <= 1'b0;
            else if (w_err_evt)
                r_err <= 1'b1;
            if (flush)
                r_flush_pend <= 1'b1;
            else if (w_flush_done)
                r_flush_pend <= 1'b0;
        end
    end

    assign ready     = w_ready;
    assign mem_wr    = r_pend_full;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_pend;
    assign err       = r_err;
    assign bit_count = r_bit_cnt;

endmodule

// File: tb/tb_t05_bit_stream_arbiter.sv
// tb_t05_bit_stream_arbiter: directed stimulus with a write scoreboard
// checked by a memory responder/monitor process.
module tb_t05_bit_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic        hdr_req = 1'b0, hdr_bit = 1'b0;
    logic        hdr_valid = 1'b0, hdr_last = 1'b0;
    logic        cmp_req = 1'b0, cmp_bit = 1'b0;
    logic        cmp_valid = 1'b0, cmp_last = 1'b0;
    logic        hdr_gnt, cmp_gnt, ready;
    logic        flush = 1'b0;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic        busy, done, err;
    logic [23:0] bit_count;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  ack_en = 1'b0;
    int  ack_wait = 0;

    t05_bit_stream_arbiter #(.WORD_W(8), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .hdr_req(hdr_req), .hdr_bit(hdr_bit),
        .hdr_valid(hdr_valid), .hdr_last(hdr_last),
        .cmp_req(cmp_req), .cmp_bit(cmp_bit),
        .cmp_valid(cmp_valid), .cmp_last(cmp_last),
        .hdr_gnt(hdr_gnt), .cmp_gnt(cmp_gnt), .ready(ready),
        .flush(flush), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy),
        .done(done), .err(err), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Memory responder and scoreboard monitor: ack one cycle after mem_wr.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (ack_en && mem_wr) begin
                if (ack_wait >= 1) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_wr: got addr %0h data %0h expected none",
                                 mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(e.a));
                        chk("wr_data", 32'(mem_wdata), 32'(e.d));
                    end
                    mem_ack  = 1'b1;
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    task automatic send_bits(input bit is_hdr, input logic [15:0] v,
                             input int n, input bit last_on_final);
        for (int i = n - 1; i >= 0; i--) begin
            if (is_hdr) begin
                hdr_valid = 1'b1;
                hdr_bit   = v[i];
                hdr_last  = last_on_final && (i == 0);
            end else begin
                cmp_valid = 1'b1;
                cmp_bit   = v[i];
                cmp_last  = last_on_final && (i == 0);
            end
            step();
        end
        hdr_valid = 1'b0; hdr_bit = 1'b0; hdr_last = 1'b0;
        cmp_valid = 1'b0; cmp_bit = 1'b0; cmp_last = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] a);
        base_addr = a;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        bit seen = 1'b0;
        for (int k = 0; k < max; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk("done_seen", 32'(seen), 32'd1);
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic wait_drain(input int max);
        bit ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            if (exp_q.size() == 0 && !mem_wr) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("drain_in_time", 32'(ok), 32'd1);
    endtask

    initial begin
        bit ok;
        // Reset state
        step(); step();
        rst = 1'b0;
        chk("rst_hdr_gnt", 32'(hdr_gnt), 32'd0);
        chk("rst_cmp_gnt", 32'(cmp_gnt), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);

        // Header only, nine bits then flush
        ack_en = 1'b1;
        do_start(16'h0100);
        push_wr(16'h0100, 8'hA0);
        push_wr(16'h0101, 8'h80);
        hdr_req = 1'b1;
        step();
        chk("t1_hdr_gnt", 32'(hdr_gnt), 32'd1);
        chk("t1_cmp_gnt", 32'(cmp_gnt), 32'd0);
        send_bits(1'b1, 16'h0141, 9, 1'b1);
        hdr_req = 1'b0;
        chk("t1_gnt_release", 32'(hdr_gnt), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_done(20);
        wait_drain(10);
        chk("t1_bit_count", 32'(bit_count), 32'd9);
        chk("t1_err", 32'(err), 32'd0);

        // Arbitration: simultaneous requests alternate
        rst = 1'b1;
        step();
        rst = 1'b0;
        hdr_req = 1'b1;
        cmp_req = 1'b1;
        step();
        chk("t2_first_hdr", 32'({hdr_gnt, cmp_gnt}), 32'b10);
        hdr_last = 1'b1;
        step();
        hdr_last = 1'b0;
        chk("t2_gap1", 32'({hdr_gnt, cmp_gnt}), 32'b00);
        step();
        chk("t2_then_cmp", 32'({hdr_gnt, cmp_gnt}), 32'b01);
        cmp_last = 1'b1;
        step();
        cmp_last = 1'b0;
        chk("t2_gap2", 32'({hdr_gnt, cmp_gnt}), 32'b00);
        step();
        chk("t2_alt_hdr", 32'({hdr_gnt, cmp_gnt}), 32'b10);
        hdr_last = 1'b1;
        step();
        hdr_last = 1'b0;
        step();
        chk("t2_alt_cmp", 32'({hdr_gnt, cmp_gnt}), 32'b01);
        cmp_last = 1'b1;
        hdr_req = 1'b0;
        cmp_req = 1'b0;
        step();
        cmp_last = 1'b0;
        step();
        chk("t2_err", 32'(err), 32'd0);

        // Backpressure with ack held low
        ack_en = 1'b0;
        do_start(16'h0200);
        cmp_req = 1'b1;
        step();
        chk("t3_cmp_gnt", 32'(cmp_gnt), 32'd1);
        send_bits(1'b0, 16'h00FF, 8, 1'b0);
        send_bits(1'b0, 16'h0007, 7, 1'b0);
        chk("t3_ready_low", 32'(ready), 32'd0);
        chk("t3_count15", 32'(bit_count), 32'd15);
        cmp_valid = 1'b1;
        cmp_bit = 1'b1;
        step();
        cmp_valid = 1'b0;
        cmp_bit = 1'b0;
        chk("t3_err_set", 32'(err), 32'd1);
        chk("t3_discard", 32'(bit_count), 32'd15);
        push_wr(16'h0200, 8'hFF);
        push_wr(16'h0201, 8'h0F);
        ack_en = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("t3_ready_back", 32'(ok), 32'd1);
        send_bits(1'b0, 16'h0001, 1, 1'b1);
        cmp_req = 1'b0;
        wait_drain(10);
        chk("t3_count16", 32'(bit_count), 32'd16);

        // start in IDLE clears err; flush held off during a grant
        do_start(16'h0300);
        chk("t5_err_clear", 32'(err), 32'd0);
        cmp_req = 1'b1;
        step();
        chk("t4_cmp_gnt", 32'(cmp_gnt), 32'd1);
        send_bits(1'b0, 16'h0005, 3, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t4_hold_gnt", 32'(cmp_gnt), 32'd1);
            chk("t4_no_wr", 32'(mem_wr), 32'd0);
            chk("t4_no_done", 32'(done), 32'd0);
            step();
        end
        push_wr(16'h0300, 8'hA0);
        cmp_last = 1'b1;
        cmp_req = 1'b0;
        step();
        cmp_last = 1'b0;
        wait_done(20);
        wait_drain(10);
        chk("t4_count", 32'(bit_count), 32'd3);
        chk("t4_err", 32'(err), 32'd0);

        // Foreign valid while hdr granted
        hdr_req = 1'b1;
        step();
        chk("t5_hdr_gnt", 32'(hdr_gnt), 32'd1);
        cmp_valid = 1'b1;
        cmp_bit = 1'b1;
        step();
        cmp_valid = 1'b0;
        cmp_bit = 1'b0;
        chk("t5_err_set", 32'(err), 32'd1);
        chk("t5_count_same", 32'(bit_count), 32'd3);
        hdr_last = 1'b1;
        hdr_req = 1'b0;
        step();
        hdr_last = 1'b0;
        do_start(16'h0400);
        chk("t5_err_start", 32'(err), 32'd0);
        chk("t5_count_zero", 32'(bit_count), 32'd0);

        // Reset while a word is pending
        ack_en = 1'b0;
        hdr_req = 1'b1;
        step();
        send_bits(1'b1, 16'h0055, 8, 1'b0);
        chk("t6_mem_wr", 32'(mem_wr), 32'd1);
        chk("t6_wdata", 32'(mem_wdata), 32'h55);
        chk("t6_addr", 32'(mem_addr), 32'h0400);
        rst = 1'b1;
        step();
        hdr_req = 1'b0;
        chk("t6_wr_off", 32'(mem_wr), 32'd0);
        chk("t6_ready", 32'(ready), 32'd1);
        chk("t6_gnts", 32'({hdr_gnt, cmp_gnt}), 32'b00);
        chk("t6_count", 32'(bit_count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        ack_en = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
